// File: rtl/req_stager.sv
// rtl/req_stager.sv - per-port request staging between sources and a fixed-priority arbiter
// Optional starvation counters are compiled in with REQ_STAGER_STARVE_EN.
module req_stager #(
  parameter int NUM_PORTS    = 5,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_PORTS-1:0]             src_valid_i,
  output logic [NUM_PORTS-1:0]             src_ready_o,
  output logic [NUM_PORTS-1:0]             req_o,
  input  logic [NUM_PORTS-1:0]             gnt_i,
  output logic [NUM_PORTS-1:0]             done_o,
  output logic [$clog2(NUM_PORTS+1)-1:0]   pend_cnt_o,
  output logic [NUM_PORTS-1:0]             starve_o,
  output logic                             err_o
);

  localparam int CNT_W = $clog2(NUM_PORTS+1);
  localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

  logic [NUM_PORTS-1:0] pend_q, pend_d;
  logic [NUM_PORTS-1:0] done_q;
  logic [CNT_W-1:0]     pend_cnt_q, pend_cnt_d;
  logic                 err_q, err_d;
  logic [NUM_PORTS-1:0] accept, retire;
  logic                 gnt_multi, gnt_orphan;

  // A port can only accept while idle and only retire while pending, so the
  // two never coincide on the same port.
  assign accept     = src_valid_i & ~pend_q;
  assign retire     = gnt_i & pend_q;
  assign gnt_multi  = |(gnt_i & (gnt_i - ONE));
  assign gnt_orphan = |(gnt_i & ~pend_q);

  always_comb begin
    pend_d     = (pend_q & ~retire) | accept;
    err_d      = err_q | gnt_multi | gnt_orphan;
    pend_cnt_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      pend_cnt_d = pend_cnt_d + CNT_W'(pend_d[p]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q     <= '0;
      done_q     <= '0;
      pend_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      done_q     <= retire;
      pend_cnt_q <= pend_cnt_d;
      err_q      <= err_d;
    end
  end

  assign src_ready_o = ~pend_q;
  assign req_o       = pend_q;
  assign done_o      = done_q;
  assign pend_cnt_o  = pend_cnt_q;
  assign err_o       = err_q;

`ifdef REQ_STAGER_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT+1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_q [NUM_PORTS];
  logic [SW-1:0] starve_cnt_d [NUM_PORTS];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      starve_cnt_d[p] = starve_cnt_q[p];
      if (retire[p] || !pend_q[p]) begin
        starve_cnt_d[p] = '0;
      end else if (starve_cnt_q[p] != LIMIT) begin
        starve_cnt_d[p] = starve_cnt_q[p] + SW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rst_i) begin
        starve_cnt_q[p] <= '0;
      end else begin
        starve_cnt_q[p] <= starve_cnt_d[p];
      end
    end
  end

  always_comb begin
    starve_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      starve_o[p] = (starve_cnt_q[p] == LIMIT);
    end
  end
`else
  assign starve_o = '0;
`endif

endmodule

// File: tb/tb_req_stager.sv
// tb/tb_req_stager.sv - directed self-checking bench for req_stager
// Starvation expectations follow REQ_STAGER_STARVE_EN when it is defined.
module tb_req_stager;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] src_valid, src_ready, req, gnt, done, starve;
  logic [2:0] pend_cnt;
  logic       err;
  int         total = 0;
  int         bad = 0;

  req_stager #(.NUM_PORTS(5), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_i(rst), .src_valid_i(src_valid), .src_ready_o(src_ready),
    .req_o(req), .gnt_i(gnt), .done_o(done), .pend_cnt_o(pend_cnt),
    .starve_o(starve), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; src_valid = '0; gnt = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; src_valid = 5'b11111; gnt = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (req !== 5'b0) begin bad++; $display("FAIL reset_req got=%b exp=00000", req); end
      total++; if (done !== 5'b0) begin bad++; $display("FAIL reset_done got=%b exp=00000", done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      total++; if (pend_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", pend_cnt); end
    end
    rst = 1'b0; src_valid = '0;
    tick();
    total++; if (src_ready !== 5'b11111) begin bad++; $display("FAIL reset_ready got=%b exp=11111", src_ready); end
    total++; if (starve !== 5'b0) begin bad++; $display("FAIL reset_starve got=%b exp=00000", starve); end
  endtask

  task automatic test_single();
    src_valid = 5'b00100;
    tick();
    src_valid = '0;
    total++; if (req !== 5'b00100) begin bad++; $display("FAIL single_req_c1 got=%b exp=00100", req); end
    total++; if (src_ready !== 5'b11011) begin bad++; $display("FAIL single_ready_c1 got=%b exp=11011", src_ready); end
    total++; if (pend_cnt !== 3'd1) begin bad++; $display("FAIL single_cnt_c1 got=%0d exp=1", pend_cnt); end
    tick();
    total++; if (req !== 5'b00100) begin bad++; $display("FAIL single_req_c2 got=%b exp=00100", req); end
    total++; if (done !== 5'b0) begin bad++; $display("FAIL single_done_c2 got=%b exp=00000", done); end
    gnt = 5'b00100;
    tick();
    gnt = '0;
    total++; if (done !== 5'b00100) begin bad++; $display("FAIL single_done_c3 got=%b exp=00100", done); end
    total++; if (req !== 5'b0) begin bad++; $display("FAIL single_req_c3 got=%b exp=00000", req); end
    total++; if (src_ready !== 5'b11111) begin bad++; $display("FAIL single_ready_c3 got=%b exp=11111", src_ready); end
    total++; if (pend_cnt !== 3'd0) begin bad++; $display("FAIL single_cnt_c3 got=%0d exp=0", pend_cnt); end
    tick();
    total++; if (done !== 5'b0) begin bad++; $display("FAIL single_done_c4 got=%b exp=00000", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", err); end
  endtask

  task automatic test_back_pressure();
    src_valid = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (pend_cnt !== 3'd1) begin bad++; $display("FAIL bp_cnt_%0d got=%0d exp=1", i, pend_cnt); end
      total++; if (src_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_ready_%0d got=%b exp=0", i, src_ready[0]); end
      total++; if (req !== 5'b00001) begin bad++; $display("FAIL bp_req_%0d got=%b exp=00001", i, req); end
    end
    gnt = 5'b00001;
    tick();
    gnt = '0;
    total++; if (done !== 5'b00001) begin bad++; $display("FAIL bp_done got=%b exp=00001", done); end
    total++; if (req !== 5'b0) begin bad++; $display("FAIL bp_req_retire got=%b exp=00000", req); end
    total++; if (src_ready[0] !== 1'b1) begin bad++; $display("FAIL bp_ready_retire got=%b exp=1", src_ready[0]); end
    tick();
    src_valid = '0;
    total++; if (req !== 5'b00001) begin bad++; $display("FAIL bp_reaccept got=%b exp=00001", req); end
    total++; if (done !== 5'b0) begin bad++; $display("FAIL bp_done_after got=%b exp=00000", done); end
    gnt = 5'b00001;
    tick();
    gnt = '0;
    tick();
    total++; if (pend_cnt !== 3'd0) begin bad++; $display("FAIL bp_drain got=%0d exp=0", pend_cnt); end
  endtask

  task automatic test_protocol_error();
    src_valid = 5'b00010;
    tick();
    src_valid = '0;
    gnt = 5'b00011;
    tick();
    gnt = '0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL perr_err got=%b exp=1", err); end
    total++; if (done !== 5'b00010) begin bad++; $display("FAIL perr_done got=%b exp=00010", done); end
    total++; if (req !== 5'b0) begin bad++; $display("FAIL perr_req got=%b exp=00000", req); end
    total++; if (src_ready !== 5'b11111) begin bad++; $display("FAIL perr_ready got=%b exp=11111", src_ready); end
    tick();
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL perr_sticky got=%b exp=1", err); end
    total++; if (done !== 5'b0) begin bad++; $display("FAIL perr_done_after got=%b exp=00000", done); end
    do_reset();
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL perr_clear got=%b exp=0", err); end
  endtask

  task automatic test_reset_mid();
    src_valid = 5'b01001;
    tick();
    src_valid = 5'b11111;
    gnt = 5'b00001;
    rst = 1'b1;
    tick();
    rst = 1'b0; gnt = '0; src_valid = '0;
    total++; if (done !== 5'b0) begin bad++; $display("FAIL rmid_done got=%b exp=00000", done); end
    total++; if (req !== 5'b0) begin bad++; $display("FAIL rmid_req got=%b exp=00000", req); end
    total++; if (pend_cnt !== 3'd0) begin bad++; $display("FAIL rmid_cnt got=%0d exp=0", pend_cnt); end
    tick();
    total++; if (done !== 5'b0) begin bad++; $display("FAIL rmid_done2 got=%b exp=00000", done); end
  endtask

  task automatic test_starve();
    logic [4:0] exp_s;
    src_valid = 5'b10000;
    tick();
    src_valid = '0;
    for (int i = 1; i <= 6; i++) begin
`ifdef REQ_STAGER_STARVE_EN
      exp_s = (i >= 5) ? 5'b10000 : 5'b00000;
`else
      exp_s = 5'b00000;
`endif
      total++; if (starve !== exp_s) begin bad++; $display("FAIL starve_wait%0d got=%b exp=%b", i, starve, exp_s); end
      if (i < 6) tick();
    end
    gnt = 5'b10000;
    tick();
    gnt = '0;
    total++; if (starve !== 5'b0) begin bad++; $display("FAIL starve_clear got=%b exp=00000", starve); end
    total++; if (done !== 5'b10000) begin bad++; $display("FAIL starve_done got=%b exp=10000", done); end
  endtask

  task automatic test_closed_loop();
    int cnt [5];
    for (int p = 0; p < 5; p++) cnt[p] = 0;
    src_valid = 5'b11111;
    for (int c = 0; c < 100; c++) begin
      gnt = req & (~req + 5'd1);
      tick();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL loop_err c=%0d got=%b exp=0", c, err); end
      total++; if ($countones(done) > 1) begin bad++; $display("FAIL loop_onehot c=%0d got=%b exp=at_most_one", c, done); end
      for (int p = 0; p < 5; p++) if (done[p]) cnt[p]++;
    end
    src_valid = '0; gnt = '0;
    for (int p = 1; p < 5; p++) begin
      total++; if (cnt[0] < cnt[p]) begin bad++; $display("FAIL loop_prio p=%0d got=%0d exp_le=%0d", p, cnt[p], cnt[0]); end
    end
    total++; if (cnt[0] < 40) begin bad++; $display("FAIL loop_port0 got=%0d exp_ge=40", cnt[0]); end
    total++; if (cnt[2] !== 0) begin bad++; $display("FAIL loop_port2 got=%0d exp=0", cnt[2]); end
  endtask

  initial begin
    rst = 1'b1; src_valid = '0; gnt = '0;
    test_reset();
    test_single();
    test_back_pressure();
    test_protocol_error();
    test_reset_mid();
    test_starve();
    do_reset();
    test_closed_loop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
